// File: rtl/egress_header_rewrite_pkg.sv
// Shared definitions for the egress header rewrite block: beat-0 field offsets,
// metadata record layout, FSM states and the incremental checksum helper.
package egress_header_rewrite_pkg;

    // Beat-0 field MSBs (byte n lives at TDATA[255-8n -: 8])
    localparam int unsigned DST_MAC_HI = 255;
    localparam int unsigned SRC_MAC_HI = 207;
    localparam int unsigned TTL_HI     = 79;
    localparam int unsigned CKSUM_HI   = 63;

    // One-hot port byte: MAC ports sit on even bits, CPU ports on odd bits
    localparam int unsigned MAC0_BIT = 0;
    localparam int unsigned MAC1_BIT = 2;
    localparam int unsigned MAC2_BIT = 4;
    localparam int unsigned MAC3_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [7:0]  dst_port;
        logic        drop;
    } meta_t;

    localparam int unsigned META_WIDTH = $bits(meta_t);

    // RFC1624 update for a TTL decrement: the TTL/proto word drops by 0x0100,
    // so ~m + m' folds into the constant 0xFEFF.
    function automatic logic [15:0] cksum_ttl_dec(input logic [15:0] hc);
        logic [16:0] s;
        logic [15:0] f;
        s = {1'b0, ~hc} + 17'h0FEFF;
        f = s[15:0] + {15'd0, s[16]};
        return ~f;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is presented on dout
// whenever the FIFO is not empty; rd_en pops it.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
)(
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);

    localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE  = (MAX_DEPTH_BITS + 1)'(1);
    localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0]   CNT_NEAR = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = MAX_DEPTH_BITS'(1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign full        = (depth == CNT_FULL);
    assign nearly_full = (depth >= CNT_NEAR);
    assign empty       = (depth == '0);
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   depth <= depth + CNT_ONE;
                2'b01:   depth <= depth - CNT_ONE;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/egress_header_rewrite.sv
// Egress IPv4 header rewrite: next-hop/source MAC substitution, TTL decrement
// with incremental checksum, TUSER port stamping and drop handling.
module egress_header_rewrite
    import egress_header_rewrite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int DST_PORT_POS         = 24,
    parameter int META_DEPTH_BITS      = 2
)(
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESET,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TLAST,

    input  logic                              meta_valid,
    output logic                              meta_ready,
    input  logic [47:0]                       meta_dst_mac,
    input  logic [7:0]                        meta_dst_port,
    input  logic                              meta_drop,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_high,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     reset,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     tx_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ttl_drop_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     meta_drop_count
);

    localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = C_S_AXI_DATA_WIDTH'(1);

    meta_t                            meta_in;
    meta_t                            meta_head;
    logic                             meta_empty;
    logic                             meta_nearly_full;
    logic                             meta_full_unused;
    logic                             meta_push;
    logic                             meta_pop;

    state_t                           state;
    state_t                           state_nxt;
    logic                             out_load;
    logic                             emit;
    logic                             use_rewrite;
    logic                             inc_tx;
    logic                             inc_ttl_drop;
    logic                             inc_meta_drop;

    logic [7:0]                       ttl_in;
    logic [47:0]                      src_mac;
    logic                             src_hit;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   rw_data;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  rw_user;
    logic                             unused_mac_high;

    assign unused_mac_high = &{1'b0, mac0_high[C_S_AXI_DATA_WIDTH-1:16], mac1_high[C_S_AXI_DATA_WIDTH-1:16],
                               mac2_high[C_S_AXI_DATA_WIDTH-1:16], mac3_high[C_S_AXI_DATA_WIDTH-1:16]};

    assign meta_in    = '{dst_mac: meta_dst_mac, dst_port: meta_dst_port, drop: meta_drop};
    assign meta_ready = !meta_nearly_full;
    assign meta_push  = meta_valid && !meta_nearly_full;

    fallthrough_small_fifo #(
        .WIDTH          (META_WIDTH),
        .MAX_DEPTH_BITS (META_DEPTH_BITS)
    ) meta_fifo (
        .din         (meta_in),
        .wr_en       (meta_push),
        .rd_en       (meta_pop),
        .dout        (meta_head),
        .full        (meta_full_unused),
        .nearly_full (meta_nearly_full),
        .empty       (meta_empty),
        .reset       (AXI_RESET),
        .clk         (AXI_ACLK)
    );

    assign out_load = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign ttl_in   = S_AXIS_TDATA[TTL_HI -: 8];

    // Lowest set MAC-port bit selects the source MAC; CPU-only ports leave it alone
    always_comb begin
        src_hit = 1'b1;
        src_mac = '0;
        if (meta_head.dst_port[MAC0_BIT]) begin
            src_mac = {mac0_high[15:0], mac0_low};
        end else if (meta_head.dst_port[MAC1_BIT]) begin
            src_mac = {mac1_high[15:0], mac1_low};
        end else if (meta_head.dst_port[MAC2_BIT]) begin
            src_mac = {mac2_high[15:0], mac2_low};
        end else if (meta_head.dst_port[MAC3_BIT]) begin
            src_mac = {mac3_high[15:0], mac3_low};
        end else begin
            src_hit = 1'b0;
        end
    end

    always_comb begin
        rw_data = S_AXIS_TDATA;
        rw_data[DST_MAC_HI -: 48] = meta_head.dst_mac;
        if (src_hit) begin
            rw_data[SRC_MAC_HI -: 48] = src_mac;
        end
        rw_data[TTL_HI -: 8]    = ttl_in - 8'd1;
        rw_data[CKSUM_HI -: 16] = cksum_ttl_dec(S_AXIS_TDATA[CKSUM_HI -: 16]);
        rw_user = S_AXIS_TUSER;
        rw_user[DST_PORT_POS +: 8] = meta_head.dst_port;
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        S_AXIS_TREADY = 1'b0;
        emit          = 1'b0;
        use_rewrite   = 1'b0;
        meta_pop      = 1'b0;
        inc_tx        = 1'b0;
        inc_ttl_drop  = 1'b0;
        inc_meta_drop = 1'b0;
        case (state)
            ST_IDLE: begin
                S_AXIS_TREADY = !meta_empty && out_load;
                if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                    meta_pop = 1'b1;
                    if (meta_head.drop) begin
                        inc_meta_drop = 1'b1;
                        if (!S_AXIS_TLAST) state_nxt = ST_DROP;
                    end else if (ttl_in <= 8'd1) begin
                        inc_ttl_drop = 1'b1;
                        if (!S_AXIS_TLAST) state_nxt = ST_DROP;
                    end else begin
                        emit        = 1'b1;
                        use_rewrite = 1'b1;
                        inc_tx      = 1'b1;
                        if (!S_AXIS_TLAST) state_nxt = ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                S_AXIS_TREADY = out_load;
                if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                    emit = 1'b1;
                    if (S_AXIS_TLAST) state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                S_AXIS_TREADY = 1'b1;
                if (S_AXIS_TVALID && S_AXIS_TLAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            M_AXIS_TVALID <= 1'b0;
        end else if (out_load) begin
            M_AXIS_TVALID <= emit;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (out_load && emit) begin
            M_AXIS_TDATA <= use_rewrite ? rw_data : S_AXIS_TDATA;
            M_AXIS_TUSER <= use_rewrite ? rw_user : S_AXIS_TUSER;
            M_AXIS_TSTRB <= S_AXIS_TSTRB;
            M_AXIS_TLAST <= S_AXIS_TLAST;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET || reset == CNT_ONE) begin
            tx_count        <= '0;
            ttl_drop_count  <= '0;
            meta_drop_count <= '0;
        end else begin
            if (inc_tx)        tx_count        <= tx_count + CNT_ONE;
            if (inc_ttl_drop)  ttl_drop_count  <= ttl_drop_count + CNT_ONE;
            if (inc_meta_drop) meta_drop_count <= meta_drop_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_egress_header_rewrite.sv
// Directed and scoreboard bench for egress_header_rewrite.
module tb_egress_header_rewrite;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int CW = 32;

    localparam logic [47:0] ORIG_DST = 48'hAAAA_BBBB_CCCC;
    localparam logic [47:0] ORIG_SRC = 48'h1111_2222_3333;
    localparam logic [47:0] MAC0 = 48'h0200_0000_0000;
    localparam logic [47:0] MAC1 = 48'h0200_0000_0001;
    localparam logic [47:0] MAC2 = 48'h0200_0000_0002;
    localparam logic [47:0] MAC3 = 48'h0200_0000_0003;

    logic AXI_ACLK = 1'b0;
    logic AXI_RESET;
    logic [DW-1:0] S_AXIS_TDATA, M_AXIS_TDATA;
    logic [SW-1:0] S_AXIS_TSTRB, M_AXIS_TSTRB;
    logic [UW-1:0] S_AXIS_TUSER, M_AXIS_TUSER;
    logic S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
    logic M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
    logic meta_valid, meta_ready, meta_drop;
    logic [47:0] meta_dst_mac;
    logic [7:0] meta_dst_port;
    logic [CW-1:0] reset, tx_count, ttl_drop_count, meta_drop_count;

    always #5 AXI_ACLK = ~AXI_ACLK;

    egress_header_rewrite #(
        .C_S_AXI_DATA_WIDTH(CW), .C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(UW),
        .DST_PORT_POS(24), .META_DEPTH_BITS(2)
    ) dut (
        .AXI_ACLK(AXI_ACLK), .AXI_RESET(AXI_RESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_dst_mac(meta_dst_mac),
        .meta_dst_port(meta_dst_port), .meta_drop(meta_drop),
        .mac0_low(32'h0000_0000), .mac0_high(32'hFFFF_0200),
        .mac1_low(32'h0000_0001), .mac1_high(32'hFFFF_0200),
        .mac2_low(32'h0000_0002), .mac2_high(32'hFFFF_0200),
        .mac3_low(32'h0000_0003), .mac3_high(32'hFFFF_0200),
        .reset(reset), .tx_count(tx_count), .ttl_drop_count(ttl_drop_count),
        .meta_drop_count(meta_drop_count)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    typedef struct {
        logic [7:0]  ttl;
        logic [15:0] hc;
        logic [7:0]  port;
        logic        drop;
        int          nb;
        logic        emit;
        logic [7:0]  ettl;
        logic [15:0] ehc;
        logic [47:0] esrc;
    } vec_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int passed = 0;
    int total = 0;
    logic rnd_ready_en = 1'b0;

    always @(negedge AXI_ACLK) begin
        if (M_AXIS_TVALID && M_AXIS_TREADY)
            got_q.push_back({M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST});
    end

    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge AXI_ACLK);
            #1;
            M_AXIS_TREADY = rnd_ready_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic beat_t mk_beat(int seed, int b, int nb, logic [7:0] ttl, logic [15:0] hc);
        beat_t x;
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(seed * 16 + b);
        x.d = {8{w}};
        x.u = {4{w ^ 32'h5A5A_A5A5}};
        x.l = (b == nb - 1);
        x.s = x.l ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        if (b == 0) begin
            x.d[255:208] = ORIG_DST;
            x.d[207:160] = ORIG_SRC;
            x.d[79:72]   = ttl;
            x.d[63:48]   = hc;
        end
        return x;
    endfunction

    function automatic beat_t rewrite(beat_t x, logic [47:0] dst, logic [47:0] src,
                                      logic [7:0] ttl, logic [15:0] hc, logic [7:0] port);
        beat_t y = x;
        y.d[255:208] = dst;
        y.d[207:160] = src;
        y.d[79:72]   = ttl;
        y.d[63:48]   = hc;
        y.u[31:24]   = port;
        return y;
    endfunction

    function automatic logic [47:0] ref_src(logic [7:0] port);
        if (port[0]) return MAC0;
        if (port[2]) return MAC1;
        if (port[4]) return MAC2;
        if (port[6]) return MAC3;
        return ORIG_SRC;
    endfunction

    function automatic logic [15:0] ref_ck(logic [15:0] hc);
        logic [31:0] s;
        s = {16'h0, ~hc} + 32'h0000_FEFF;
        s = (s & 32'h0000_FFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic push_meta(input logic [47:0] mac, input logic [7:0] port, input logic drop);
        int n = 0;
        meta_valid = 1'b1; meta_dst_mac = mac; meta_dst_port = port; meta_drop = drop;
        @(negedge AXI_ACLK);
        while (!meta_ready && n < 200) begin @(negedge AXI_ACLK); n++; end
        if (!meta_ready) begin total++; $display("FAIL meta_ready timeout: got 0 want 1"); end
        @(posedge AXI_ACLK); #1;
        meta_valid = 1'b0;
    endtask

    task automatic send_beat(input beat_t b);
        int n = 0;
        S_AXIS_TDATA = b.d; S_AXIS_TUSER = b.u; S_AXIS_TSTRB = b.s; S_AXIS_TLAST = b.l;
        S_AXIS_TVALID = 1'b1;
        @(negedge AXI_ACLK);
        while (!S_AXIS_TREADY && n < 200) begin @(negedge AXI_ACLK); n++; end
        if (!S_AXIS_TREADY) begin total++; $display("FAIL s_tready timeout: got 0 want 1"); end
        @(posedge AXI_ACLK); #1;
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic send_pkt(input int seed, input int nb, input logic [7:0] ttl, input logic [15:0] hc);
        for (int b = 0; b < nb; b++) send_beat(mk_beat(seed, b, nb, ttl, hc));
    endtask

    task automatic drain(input int want, input string name);
        int n = 0;
        while (got_q.size() < want && n < 5000) begin @(negedge AXI_ACLK); n++; end
        repeat (8) @(negedge AXI_ACLK);
        chk({name, " beat count"}, 256'(got_q.size()), 256'(want));
        @(posedge AXI_ACLK); #1;
    endtask

    task automatic cmp_beat(input string name, input beat_t act, input beat_t exp);
        chk({name, " data"}, act.d, exp.d);
        chk({name, " user/strb/last"}, 256'({act.u, act.s, act.l}), 256'({exp.u, exp.s, exp.l}));
    endtask

    task automatic chk_counters(input string name, input int tx, input int td, input int md);
        chk({name, " tx_count"}, 256'(tx_count), 256'(tx));
        chk({name, " ttl_drop_count"}, 256'(ttl_drop_count), 256'(td));
        chk({name, " meta_drop_count"}, 256'(meta_drop_count), 256'(md));
    endtask

    vec_t tbl[8];

    initial begin
        logic [47:0] mac;
        beat_t x;
        int exp_tx, exp_td, exp_md;

        tbl[0] = '{8'd64,  16'hB861, 8'h04, 1'b0, 2, 1'b1, 8'd63,  16'hB961, MAC1};
        tbl[1] = '{8'd2,   16'hFEFF, 8'h01, 1'b0, 3, 1'b1, 8'd1,   16'h0000, MAC0};
        tbl[2] = '{8'd1,   16'h1234, 8'h10, 1'b0, 4, 1'b0, 8'd0,   16'h0000, MAC0};
        tbl[3] = '{8'd0,   16'h5555, 8'h04, 1'b0, 1, 1'b0, 8'd0,   16'h0000, MAC0};
        tbl[4] = '{8'd64,  16'hB861, 8'h04, 1'b1, 2, 1'b0, 8'd0,   16'h0000, MAC0};
        tbl[5] = '{8'd10,  16'h0000, 8'h80, 1'b0, 1, 1'b1, 8'd9,   16'h0100, ORIG_SRC};
        tbl[6] = '{8'd255, 16'h0100, 8'h50, 1'b0, 2, 1'b1, 8'd254, 16'h0200, MAC2};
        tbl[7] = '{8'd3,   16'hFFFF, 8'h0C, 1'b0, 2, 1'b1, 8'd2,   16'h0100, MAC1};

        AXI_RESET = 1'b1; reset = '0;
        S_AXIS_TDATA = '0; S_AXIS_TUSER = '0; S_AXIS_TSTRB = '0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
        meta_valid = 1'b0; meta_dst_mac = '0; meta_dst_port = '0; meta_drop = 1'b0;
        repeat (3) @(posedge AXI_ACLK);
        #1 AXI_RESET = 1'b0;
        @(negedge AXI_ACLK);
        chk("reset m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
        chk("reset meta_ready", 256'(meta_ready), 256'(1));
        chk_counters("reset", 0, 0, 0);
        @(posedge AXI_ACLK); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            mac = 48'h0A0B_0C0D_0E00 + 48'(i);
            got_q.delete();
            push_meta(mac, tbl[i].port, tbl[i].drop);
            send_pkt(i, tbl[i].nb, tbl[i].ttl, tbl[i].hc);
            drain(tbl[i].emit ? tbl[i].nb : 0, $sformatf("vec%0d", i));
            if (tbl[i].emit && got_q.size() == tbl[i].nb) begin
                for (int b = 0; b < tbl[i].nb; b++) begin
                    x = mk_beat(i, b, tbl[i].nb, tbl[i].ttl, tbl[i].hc);
                    if (b == 0) x = rewrite(x, mac, tbl[i].esrc, tbl[i].ettl, tbl[i].ehc, tbl[i].port);
                    cmp_beat($sformatf("vec%0d beat%0d", i, b), got_q[b], x);
                end
            end
        end
        chk_counters("table", 5, 2, 1);

        // Meta drop followed back-to-back by a normal packet; second meta pushed as first is decided
        got_q.delete();
        push_meta(48'hDEAD_0000_0001, 8'h04, 1'b1);
        fork
            send_pkt(500, 2, 8'd64, 16'hB861);
            push_meta(48'hBEEF_0000_0002, 8'h40, 1'b0);
        join
        send_pkt(501, 2, 8'd20, 16'h1000);
        drain(2, "b2b");
        if (got_q.size() == 2) begin
            cmp_beat("b2b beat0", got_q[0],
                     rewrite(mk_beat(501, 0, 2, 8'd20, 16'h1000), 48'hBEEF_0000_0002, MAC3, 8'd19, 16'h1100, 8'h40));
            cmp_beat("b2b beat1", got_q[1], mk_beat(501, 1, 2, 8'd20, 16'h1000));
        end
        chk_counters("b2b", 6, 2, 2);

        // Counter clear register: only the value 1 clears
        reset = 32'd2; @(posedge AXI_ACLK); #1; reset = '0;
        @(negedge AXI_ACLK);
        chk_counters("clr2", 6, 2, 2);
        @(posedge AXI_ACLK); #1;
        reset = 32'd1; @(posedge AXI_ACLK); #1; reset = '0;
        @(negedge AXI_ACLK);
        chk_counters("clr1", 0, 0, 0);
        @(posedge AXI_ACLK); #1;

        // Random backpressure scoreboard
        got_q.delete(); exp_q.delete();
        exp_tx = 0; exp_td = 0; exp_md = 0;
        rnd_ready_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int nb;
            logic [7:0] ttl, port;
            logic [15:0] hc;
            logic drop;
            nb   = $urandom_range(1, 4);
            ttl  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 255));
            hc   = 16'($urandom);
            port = 8'($urandom);
            drop = ($urandom_range(0, 5) == 0);
            mac  = {16'($urandom), 32'($urandom)};
            if (drop) exp_md++;
            else if (ttl <= 8'd1) exp_td++;
            else begin
                exp_tx++;
                for (int b = 0; b < nb; b++) begin
                    x = mk_beat(100 + p, b, nb, ttl, hc);
                    if (b == 0) x = rewrite(x, mac, ref_src(port), ttl - 8'd1, ref_ck(hc), port);
                    exp_q.push_back(x);
                end
            end
            push_meta(mac, port, drop);
            send_pkt(100 + p, nb, ttl, hc);
        end
        drain(exp_q.size(), "random");
        rnd_ready_en = 1'b0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            cmp_beat($sformatf("random beat%0d", i), got_q[i], exp_q[i]);
        chk_counters("random", exp_tx, exp_td, exp_md);
        repeat (2) @(posedge AXI_ACLK);
        #1;

        // AXI_RESET in the middle of a forwarded packet
        push_meta(48'h0A0B_0C0D_0EEE, 8'h01, 1'b0);
        send_beat(mk_beat(900, 0, 4, 8'd64, 16'h4000));
        send_beat(mk_beat(900, 1, 4, 8'd64, 16'h4000));
        AXI_RESET = 1'b1; @(posedge AXI_ACLK); #1; AXI_RESET = 1'b0;
        @(negedge AXI_ACLK);
        chk("midreset m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
        chk_counters("midreset", 0, 0, 0);
        @(posedge AXI_ACLK); #1;
        x = mk_beat(901, 0, 2, 8'd33, 16'h2222);
        S_AXIS_TDATA = x.d; S_AXIS_TUSER = x.u; S_AXIS_TSTRB = x.s; S_AXIS_TLAST = x.l;
        S_AXIS_TVALID = 1'b1;
        @(negedge AXI_ACLK);
        chk("idle no-meta s_tready", 256'(S_AXIS_TREADY), 256'(0));
        @(posedge AXI_ACLK); #1;
        S_AXIS_TVALID = 1'b0;
        got_q.delete();
        push_meta(48'h0A0B_0C0D_0EEF, 8'h04, 1'b0);
        send_pkt(901, 2, 8'd33, 16'h2222);
        drain(2, "restart");
        if (got_q.size() == 2) begin
            cmp_beat("restart beat0", got_q[0],
                     rewrite(mk_beat(901, 0, 2, 8'd33, 16'h2222), 48'h0A0B_0C0D_0EEF, MAC1, 8'd32, 16'h2322, 8'h04));
            cmp_beat("restart beat1", got_q[1], mk_beat(901, 1, 2, 8'd33, 16'h2222));
        end
        chk_counters("restart", 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
